sort_sequencer_8: RTL and testbench

- Serial sort engine for 8-bit unsigned operands.
- Loads up to DEPTH values, sorts them in place by bubble passes, then streams the sorted values out.
- All ordering decisions are made by exactly one shared comparator_8 instance, used once per cycle; the sequencer owns its operand muxing and the swap decision.
- Used as a pre-ordering stage ahead of the multiplier datapath.

---
 rtl/sort_sequencer_8.sv | 145 ++++++++++++++
 tb/tb_sort_sequencer_8.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sort_sequencer_8.sv
// Serial bubble-sort engine for 8-bit unsigned values: load, sort in place, drain.
// One shared comparator makes every ordering decision, one compare per SORT cycle.

module comparator_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       a_gt_b,
  output logic       a_lt_b
);
  assign a_gt_b = (a > b);
  assign a_lt_b = (a < b);
endmodule

module sort_sequencer_8 #(
  parameter int DEPTH   = 8,
  parameter bit DESCEND = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       start,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [4:0] count
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SORT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0] state;
  logic [7:0] entry [DEPTH];
  logic [4:0] count_r;
  logic [4:0] idx;
  logic [4:0] limit;
  logic [4:0] rd;
  logic       swapped;
  logic       done_r;

  logic       load_ok;
  logic [4:0] count_nx;
  logic [4:0] idx_nx;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       a_gt_b;
  logic       a_lt_b;
  logic       swap_now;
  logic       pass_end;
  logic       last_out;

  assign load_ok  = (state == ST_LOAD) && in_valid && (count_r < DEPTH_C);
  assign count_nx = count_r + {4'd0, load_ok};
  assign idx_nx   = idx + 5'd1;
  assign op_a     = entry[idx[AW-1:0]];
  assign op_b     = entry[idx_nx[AW-1:0]];

  comparator_8 u_cmp (
    .a      (op_a),
    .b      (op_b),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b)
  );

  // Equal operands never swap, which keeps the sort stable.
  assign swap_now = (state == ST_SORT) && (limit != 5'd0) && (DESCEND ? a_lt_b : a_gt_b);
  assign pass_end = (idx_nx == limit);
  assign last_out = (rd == count_r - 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_LOAD;
      count_r <= 5'd0;
      idx     <= 5'd0;
      limit   <= 5'd0;
      rd      <= 5'd0;
      swapped <= 1'b0;
      done_r  <= 1'b0;
      for (int k = 0; k < DEPTH; k++) entry[k] <= 8'd0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (load_ok) entry[count_r[AW-1:0]] <= in_data;
          count_r <= count_nx;
          // A load in the same cycle as start is part of the job.
          if (start && (count_nx != 5'd0)) begin
            state   <= ST_SORT;
            idx     <= 5'd0;
            limit   <= count_nx - 5'd1;
            swapped <= 1'b0;
          end
        end
        ST_SORT: begin
          if (limit == 5'd0) begin
            state <= ST_DRAIN;
          end else begin
            if (swap_now) begin
              entry[idx[AW-1:0]]    <= op_b;
              entry[idx_nx[AW-1:0]] <= op_a;
            end
            if (pass_end) begin
              if (!(swapped || swap_now) || (limit == 5'd1)) begin
                state <= ST_DRAIN;
              end else begin
                limit   <= limit - 5'd1;
                idx     <= 5'd0;
                swapped <= 1'b0;
              end
            end else begin
              idx     <= idx_nx;
              swapped <= swapped || swap_now;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (last_out) begin
              state   <= ST_LOAD;
              count_r <= 5'd0;
              rd      <= 5'd0;
              done_r  <= 1'b1;
            end else begin
              rd <= rd + 5'd1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign in_ready  = (state == ST_LOAD) && (count_r < DEPTH_C);
  assign out_valid = (state == ST_DRAIN);
  assign out_data  = out_valid ? entry[rd[AW-1:0]] : 8'd0;
  assign busy      = (state == ST_SORT) || (state == ST_DRAIN);
  assign done      = done_r;
  assign count     = count_r;
endmodule

// File: tb/tb_sort_sequencer_8.sv
// Bench for sort_sequencer_8: an ascending and a descending instance share clock and reset;
// expected outputs are queued at stimulus time and a monitor checks every accepted element.

module tb_sort_sequencer_8;
  logic       clk;
  logic       rst;
  logic       in_valid  [2];
  logic [7:0] in_data   [2];
  logic       in_ready  [2];
  logic       start     [2];
  logic       out_valid [2];
  logic [7:0] out_data  [2];
  logic       out_ready [2];
  logic       busy      [2];
  logic       done      [2];
  logic [4:0] count     [2];

  logic [7:0] exp_q[$];
  int checks;
  int failures;

  sort_sequencer_8 #(.DEPTH(8), .DESCEND(1'b0)) dut_asc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .start(start[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .done(done[0]), .count(count[0])
  );

  sort_sequencer_8 #(.DEPTH(8), .DESCEND(1'b1)) dut_desc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .start(start[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .done(done[1]), .count(count[1])
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every accepted output element is popped and compared.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && out_valid[d] && out_ready[d]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out inst=%0d got=%0h want=none", d, out_data[d]);
        end else begin
          check("out_data", {24'd0, out_data[d]}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Driver tasks: each is entered and left 1 time unit after a rising edge.
  task automatic load(input int d, input logic [7:0] v);
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic load_start(input int d, input logic [7:0] v);
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    start[d]    = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    start[d]    = 1'b0;
  endtask

  task automatic run_job(input int d, input int exp_sort, input bit bp);
    int n;
    int c;
    logic [7:0] held;
    n = 0;
    held = 8'd0;
    while (busy[d] && !out_valid[d] && n < 300) begin
      if (n == 0) check("in_ready_sort", {31'd0, in_ready[d]}, 32'd0);
      n++;
      @(posedge clk); #1;
    end
    check("sort_cycles", n, exp_sort);
    c = 0;
    while (!done[d] && c < 100) begin
      out_ready[d] = !(bp && c >= 2 && c < 5);
      if (bp && c == 2) held = out_data[d];
      if (bp && c > 2 && c <= 5) check("hold_stable", {24'd0, out_data[d]}, {24'd0, held});
      @(posedge clk); #1;
      c++;
    end
    out_ready[d] = 1'b0;
    check("done_seen", {31'd0, done[d]}, 32'd1);
    check("count_after", {27'd0, count[d]}, 32'd0);
    check("valid_after", {31'd0, out_valid[d]}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done[d]}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = 8'd0;
      start[d]     = 1'b0;
      out_ready[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready",  {31'd0, in_ready[d]},  32'd1);
      check("rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
      check("rst_out_data",  {24'd0, out_data[d]},  32'd0);
      check("rst_busy",      {31'd0, busy[d]},      32'd0);
      check("rst_done",      {31'd0, done[d]},      32'd0);
      check("rst_count",     {27'd0, count[d]},     32'd0);
    end

    // Basic ascending: 5,3,9,1 -> 1,3,5,9 after 3+2+1 compares
    load(0, 8'd5); load(0, 8'd3); load(0, 8'd9); load(0, 8'd1);
    check("count_4", {27'd0, count[0]}, 32'd4);
    exp_q.push_back(8'd1); exp_q.push_back(8'd3); exp_q.push_back(8'd5); exp_q.push_back(8'd9);
    pulse_start(0);
    run_job(0, 6, 1'b0);

    // Full and presorted: one pass of 7 compares, order unchanged
    for (int k = 1; k <= 8; k++) load(0, 8'(k * 16));
    check("full_in_ready", {31'd0, in_ready[0]}, 32'd0);
    load(0, 8'h99);
    check("full_count", {27'd0, count[0]}, 32'd8);
    for (int k = 1; k <= 8; k++) exp_q.push_back(8'(k * 16));
    pulse_start(0);
    run_job(0, 7, 1'b0);

    // Duplicates, descending, unsigned extremes: passes of 4,3,2 compares
    load(1, 8'h07); load(1, 8'h07); load(1, 8'hFF); load(1, 8'h00); load(1, 8'h07);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h07); exp_q.push_back(8'h07);
    exp_q.push_back(8'h07); exp_q.push_back(8'h00);
    pulse_start(1);
    run_job(1, 9, 1'b0);

    // Backpressure mid-drain: 4,2,8,6 -> 2,4,6,8 after passes of 3,2
    load(0, 8'd4); load(0, 8'd2); load(0, 8'd8); load(0, 8'd6);
    exp_q.push_back(8'd2); exp_q.push_back(8'd4); exp_q.push_back(8'd6); exp_q.push_back(8'd8);
    pulse_start(0);
    run_job(0, 5, 1'b1);

    // start with nothing loaded stays in LOAD
    pulse_start(0);
    check("empty_start_busy",  {31'd0, busy[0]},     32'd0);
    check("empty_start_ready", {31'd0, in_ready[0]}, 32'd1);
    check("empty_start_valid", {31'd0, out_valid[0]}, 32'd0);
    @(posedge clk); #1;
    check("empty_start_busy2", {31'd0, busy[0]},     32'd0);

    // Single load with start in the same cycle: one SORT cycle
    exp_q.push_back(8'h42);
    load_start(0, 8'h42);
    run_job(0, 1, 1'b0);

    // Reset during the second pass of 5,4,3,2,1
    load(0, 8'd5); load(0, 8'd4); load(0, 8'd3); load(0, 8'd2); load(0, 8'd1);
    pulse_start(0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_in_ready",  {31'd0, in_ready[0]},  32'd1);
    check("midrst_busy",      {31'd0, busy[0]},      32'd0);
    check("midrst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("midrst_out_data",  {24'd0, out_data[0]},  32'd0);
    check("midrst_done",      {31'd0, done[0]},      32'd0);
    check("midrst_count",     {27'd0, count[0]},     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    load(0, 8'd2); load(0, 8'd1);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    pulse_start(0);
    run_job(0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
